// File: rtl/hsk_pkg.sv
//-----------------------------------------------------------------------------
// Module  : hsk_pkg
// Brief   : Shared constants, types and helpers for handshake_rr_buf.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package hsk_pkg;

    localparam int REJ_CNT_W = 16;

    // Wide enough for the largest supported channel count (16).
    typedef logic [3:0] ch_idx_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/handshake_rr_buf_if.sv
//-----------------------------------------------------------------------------
// Module  : handshake_rr_buf_if
// Brief   : Producer-side and consumer-side handshake bundle for handshake_rr_buf.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

interface handshake_rr_buf_if
    import hsk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CH_W  = clog2_min1(NCH)
);
    logic [NCH-1:0]       sready;
    logic [NCH*WIDTH-1:0] din;
    logic [NCH-1:0]       sidle;
    logic                 dbusy;
    logic                 dvalid;
    logic [WIDTH-1:0]     dout;
    logic [CH_W-1:0]      dch;

    modport master (output sready, din, dbusy, input  sidle, dvalid, dout, dch);
    modport slave  (input  sready, din, dbusy, output sidle, dvalid, dout, dch);
endinterface

`default_nettype wire

// File: rtl/hsk_fifo_ch.sv
//-----------------------------------------------------------------------------
// Module  : hsk_fifo_ch
// Brief   : Single-channel synchronous FIFO with wrap-bit pointers.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module hsk_fifo_ch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [WIDTH-1:0]      rdata_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with opposite wrap bit means the writer lapped the reader.
    assign full_o    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty_o   = (wptr_q == rptr_q);
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_push) wptr_q <= wptr_q + c_PTR_ONE;
            if (w_do_pop)  rptr_q <= rptr_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/handshake_rr_buf.sv
//-----------------------------------------------------------------------------
// Module  : handshake_rr_buf
// Brief   : NCH per-channel FIFOs drained one word per cycle by a round-robin
//           arbiter. Define HSK_REJECT_CNT_EN to add the stat_reject counter.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module handshake_rr_buf
    import hsk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    handshake_rr_buf_if.slave bus
`ifdef HSK_REJECT_CNT_EN
    ,
    output logic [REJ_CNT_W-1:0] stat_reject
`endif
);
    localparam int CH_W = clog2_min1(NCH);

    logic [NCH-1:0]   w_full;
    logic [NCH-1:0]   w_empty;
    logic [NCH-1:0]   w_push;
    logic [NCH-1:0]   w_pop;
    logic [WIDTH-1:0] w_rdata [NCH];
    ch_idx_t          w_grant;
    logic             w_any;
    logic             w_do_pop;

    ch_idx_t          last_q;
    logic             dvalid_q;
    logic [WIDTH-1:0] dout_q;
    logic [CH_W-1:0]  dch_q;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            assign w_push[g] = bus.sready[g] & ~w_full[g];
            assign w_pop[g]  = w_do_pop && (w_grant == ch_idx_t'(g));

            hsk_fifo_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push_i  (w_push[g]),
                .pop_i   (w_pop[g]),
                .wdata_i (bus.din[g*WIDTH +: WIDTH]),
                .full_o  (w_full[g]),
                .empty_o (w_empty[g]),
                .rdata_o (w_rdata[g])
            );
        end
    endgenerate

    // Scan from the farthest candidate back to last+1 so the nearest non-empty one wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = last_q;
        w_any   = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            idx = (int'(last_q) + i) % NCH;
            if (!w_empty[idx[CH_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = ch_idx_t'(idx);
            end
        end
    end

    assign w_do_pop = w_any & ~bus.dbusy;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= ch_idx_t'(NCH - 1);
            dvalid_q <= 1'b0;
            dout_q   <= '0;
            dch_q    <= '0;
        end else if (w_do_pop) begin
            last_q   <= w_grant;
            dvalid_q <= 1'b1;
            dout_q   <= w_rdata[w_grant[CH_W-1:0]];
            dch_q    <= w_grant[CH_W-1:0];
        end else begin
            dvalid_q <= 1'b0;
        end
    end

    assign bus.sidle  = ~w_full;
    assign bus.dvalid = dvalid_q;
    assign bus.dout   = dout_q;
    assign bus.dch    = dch_q;

`ifdef HSK_REJECT_CNT_EN
    logic [REJ_CNT_W-1:0] rej_q;
    logic [REJ_CNT_W:0]   w_rej_sum;

    always_comb begin
        w_rej_sum = {1'b0, rej_q};
        for (int c = 0; c < NCH; c++) begin
            w_rej_sum = w_rej_sum + (REJ_CNT_W+1)'(bus.sready[c] & w_full[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                       rej_q <= '0;
        else if (w_rej_sum[REJ_CNT_W]) rej_q <= '1;
        else                           rej_q <= w_rej_sum[REJ_CNT_W-1:0];
    end

    assign stat_reject = rej_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_handshake_rr_buf.sv
//-----------------------------------------------------------------------------
// Module  : tb_handshake_rr_buf
// Brief   : Self-checking bench: vector table, corner sequences, random traffic.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_handshake_rr_buf;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int CH_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    handshake_rr_buf_if #(.WIDTH(WIDTH), .NCH(NCH), .CH_W(CH_W)) bus ();
`ifdef HSK_REJECT_CNT_EN
    logic [15:0] stat_reject;
`endif

    handshake_rr_buf #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef HSK_REJECT_CNT_EN
        ,
        .stat_reject (stat_reject)
`endif
    );

    // Reference model: one queue per channel plus the last-served channel.
    logic [WIDTH-1:0] mq [NCH][$];
    int               m_last  = NCH - 1;
    logic             m_dv    = 1'b0;
    logic [WIDTH-1:0] m_dout  = '0;
    int               m_dch   = 0;
    int               m_rej   = 0;
    bit               m_valid = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NCH-1:0] sr,
                              input logic [NCH*WIDTH-1:0] d, input logic b);
        bit acc [NCH];
        if (r) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_last = NCH - 1; m_dv = 1'b0; m_dout = '0; m_dch = 0; m_rej = 0;
            m_valid = 1'b1;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            acc[c] = sr[c] && (mq[c].size() < DEPTH);
            if (sr[c] && !acc[c]) m_rej = (m_rej >= 65535) ? 65535 : m_rej + 1;
        end
        m_dv = 1'b0;
        if (!b) begin
            for (int k = 1; k <= NCH; k++) begin
                int c = (m_last + k) % NCH;
                if (mq[c].size() > 0) begin
                    m_dout = mq[c].pop_front();
                    m_dch  = c;
                    m_last = c;
                    m_dv   = 1'b1;
                    break;
                end
            end
        end
        for (int c = 0; c < NCH; c++)
            if (acc[c]) mq[c].push_back(d[c*WIDTH +: WIDTH]);
    endtask

    task automatic cycle(input logic r, input logic [NCH-1:0] sr,
                         input logic [NCH*WIDTH-1:0] d, input logic b);
        logic [NCH-1:0] e_idle;
        @(negedge clk);
        rst = r; bus.sready = sr; bus.din = d; bus.dbusy = b;
        #1;
        for (int c = 0; c < NCH; c++) e_idle[c] = (mq[c].size() < DEPTH);
        if (m_valid) chk("model_sidle", bus.sidle, e_idle);
        @(posedge clk);
        model_edge(r, sr, d, b);
        #1;
        if (m_valid) begin
            chk("model_dvalid", bus.dvalid, m_dv);
            chk("model_dout", bus.dout, m_dout);
            chk("model_dch", bus.dch, m_dch);
`ifdef HSK_REJECT_CNT_EN
            chk("model_reject", stat_reject, m_rej);
`endif
        end
    endtask

    typedef struct {
        logic                 r;
        logic [NCH-1:0]       sr;
        logic [NCH*WIDTH-1:0] d;
        logic                 b;
        logic [NCH-1:0]       e_sidle;
        logic                 e_dv;
        logic [WIDTH-1:0]     e_dout;
        logic [CH_W-1:0]      e_dch;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [7:0] exp_dout [6];
        logic [1:0] exp_dch  [6];
        int         got;

        bus.sready = '0; bus.din = '0; bus.dbusy = 1'b1;

        // din packing: {ch3, ch2, ch1, ch0}
        tbl[0]  = '{1'b1, 4'h0, 32'h0,        1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b0, 4'h4, 32'h00A50000, 1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[2]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b1, 8'hA5, 2'd2};
        tbl[3]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b0, 8'hA5, 2'd2};
        tbl[4]  = '{1'b1, 4'h0, 32'h0,        1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[5]  = '{1'b0, 4'hF, 32'h44332211, 1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[6]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b1, 8'h11, 2'd0};
        tbl[7]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b1, 8'h22, 2'd1};
        tbl[8]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b1, 8'h33, 2'd2};
        tbl[9]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b1, 8'h44, 2'd3};
        tbl[10] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b0, 8'h44, 2'd3};
        tbl[11] = '{1'b0, 4'h3, 32'h00006655, 1'b1, 4'hF, 1'b0, 8'h44, 2'd3};
        tbl[12] = '{1'b1, 4'hF, 32'h0,        1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[13] = '{1'b1, 4'hF, 32'h0,        1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[14] = '{1'b1, 4'hF, 32'h0,        1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[15] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b0, 8'h00, 2'd0};
        tbl[16] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'hF, 1'b0, 8'h00, 2'd0};

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].r, tbl[i].sr, tbl[i].d, tbl[i].b);
            chk($sformatf("tbl%0d_sidle", i),  bus.sidle,  tbl[i].e_sidle);
            chk($sformatf("tbl%0d_dvalid", i), bus.dvalid, tbl[i].e_dv);
            chk($sformatf("tbl%0d_dout", i),   bus.dout,   tbl[i].e_dout);
            chk($sformatf("tbl%0d_dch", i),    bus.dch,    tbl[i].e_dch);
        end

        // Channel 1 overfill: fifth word waits until a pop frees a slot.
        cycle(1'b1, 4'h0, 32'h0, 1'b1);
        for (int w = 0; w < 4; w++) cycle(1'b0, 4'h2, {16'h0, 8'(8'h10 + w), 8'h0}, 1'b1);
        chk("ovf_full_after4", bus.sidle[1], 1'b0);
        cycle(1'b0, 4'h2, 32'h00001400, 1'b1);
        chk("ovf_still_full", bus.sidle[1], 1'b0);
        cycle(1'b0, 4'h2, 32'h00001400, 1'b0);
        chk("ovf_pop_dvalid", bus.dvalid, 1'b1);
        chk("ovf_pop_dout", bus.dout, 8'h10);
        chk("ovf_slot_free", bus.sidle[1], 1'b1);
        cycle(1'b0, 4'h2, 32'h00001400, 1'b1);
        chk("ovf_fifth_taken", bus.sidle[1], 1'b0);
        for (int w = 0; w < 4; w++) begin
            cycle(1'b0, 4'h0, 32'h0, 1'b0);
            chk("ovf_drain_dout", bus.dout, 8'(8'h11 + w));
        end

        // ch0 and ch3 both backlogged: service alternates, stalls lose nothing.
        cycle(1'b1, 4'h0, 32'h0, 1'b1);
        for (int w = 0; w < 3; w++) cycle(1'b0, 4'h9, {8'(8'hD0 + w), 16'h0, 8'(8'hA0 + w)}, 1'b1);
        for (int w = 0; w < 3; w++) begin
            exp_dout[2*w] = 8'(8'hA0 + w); exp_dch[2*w] = 2'd0;
            exp_dout[2*w+1] = 8'(8'hD0 + w); exp_dch[2*w+1] = 2'd3;
        end
        got = 0;
        for (int t = 0; t < 12 && got < 6; t++) begin
            logic busy;
            busy = (t % 3 == 2);
            cycle(1'b0, 4'h0, 32'h0, busy);
            if (busy) chk("rr_busy_dvalid", bus.dvalid, 1'b0);
            else if (bus.dvalid) begin
                chk("rr_dch", bus.dch, exp_dch[got]);
                chk("rr_dout", bus.dout, exp_dout[got]);
                got++;
            end
        end
        chk("rr_delivered", got, 6);

`ifdef HSK_REJECT_CNT_EN
        cycle(1'b1, 4'h0, 32'h0, 1'b1);
        for (int w = 0; w < DEPTH; w++) cycle(1'b0, 4'hF, $urandom, 1'b1);
        for (int w = 0; w < 10; w++) cycle(1'b0, 4'h1, $urandom, 1'b1);
        chk("rej_ten", stat_reject, 16'd10);
        for (int w = 0; w < 16400; w++) cycle(1'b0, 4'hF, $urandom, 1'b1);
        chk("rej_saturate", stat_reject, 16'hFFFF);
        for (int w = 0; w < 5; w++) cycle(1'b0, 4'hF, $urandom, 1'b1);
        chk("rej_hold", stat_reject, 16'hFFFF);
`endif

        cycle(1'b1, 4'h0, 32'h0, 1'b1);
        for (int t = 0; t < 3000; t++) begin
            cycle(($urandom_range(0, 199) == 0), 4'($urandom), $urandom,
                  ($urandom_range(0, 9) < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
